// File: rtl/qdec_cabac_package.sv
// Shared types and constants for the CABAC transform-unit sequencer.
// The residual iteration order follows the bit order of the chroma mask.
package qdec_cabac_package;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EVAL  = 3'd1,
      ST_DQP   = 3'd2,
      ST_CQP   = 3'd3,
      ST_RES_Y = 3'd4,
      ST_RES_C = 3'd5,
      ST_DONE  = 3'd6
   } t_state_tu_seq;

   typedef enum logic [1:0] {
      SUB_DQP = 2'd0,
      SUB_CQP = 2'd1,
      SUB_RES = 2'd2
   } t_sub_sel;

   localparam logic [1:0] CHROMA_400 = 2'd0;
   localparam logic [1:0] CHROMA_420 = 2'd1;
   localparam logic [1:0] CHROMA_422 = 2'd2;
   localparam logic [1:0] CHROMA_444 = 2'd3;

   localparam logic [1:0] CIDX_Y  = 2'd0;
   localparam logic [1:0] CIDX_CB = 2'd1;
   localparam logic [1:0] CIDX_CR = 2'd2;

   typedef struct packed {
      logic [1:0] chroma_format_idc;
      logic [2:0] log2_size;
      logic [1:0] blk_idx;
      logic       cbf_luma;
      logic [1:0] cbf_cb;
      logic [1:0] cbf_cr;
      logic [1:0] parent_cbf_cb;
      logic [1:0] parent_cbf_cr;
      logic       bypass;
      logic       dqp_en;
      logic       dqp_coded;
      logic       cqp_en;
      logic       cqp_coded;
   } t_tu_cfg;

   // Mask bits are {Cr1,Cr0,Cb1,Cb0}; lowest set bit is decoded next.
   function automatic logic [1:0] first_set(input logic [3:0] m);
      if (m[0])      first_set = 2'd0;
      else if (m[1]) first_set = 2'd1;
      else if (m[2]) first_set = 2'd2;
      else           first_set = 2'd3;
   endfunction

endpackage

// File: rtl/qdec_tu_chroma_plan.sv
// Combinational chroma planner: turns the latched TU configuration into the
// chroma residual mask, chroma block size, cbfChroma and configuration error.
module qdec_tu_chroma_plan
   import qdec_cabac_package::*;
#(
   parameter int unsigned MAX_LOG2_TB = 5,
   parameter bit          SUPPORT_422 = 1'b1,
   parameter bit          SUPPORT_444 = 1'b1
) (
   input  logic [1:0] chroma_format_idc,
   input  logic [2:0] log2_size,
   input  logic [1:0] blk_idx,
   input  logic [1:0] cbf_cb,
   input  logic [1:0] cbf_cr,
   input  logic [1:0] parent_cbf_cb,
   input  logic [1:0] parent_cbf_cr,
   output logic [3:0] chroma_mask,
   output logic [2:0] log2_c,
   output logic       cbf_chroma,
   output logic       cfg_err
);

   localparam logic [2:0] MAX_LOG2 = 3'(MAX_LOG2_TB);

   logic [3:0] cbf_bits;
   logic       sub1_en;

   always_comb begin
      cbf_bits    = '0;
      chroma_mask = '0;
      log2_c      = log2_size;
      sub1_en     = (chroma_format_idc == CHROMA_422);
      cfg_err     = (log2_size < 3'd2) || (log2_size > MAX_LOG2) ||
                    ((chroma_format_idc == CHROMA_422) && !SUPPORT_422) ||
                    ((chroma_format_idc == CHROMA_444) && !SUPPORT_444);
      case (chroma_format_idc)
         CHROMA_444: begin
            cbf_bits    = {1'b0, cbf_cr[0], 1'b0, cbf_cb[0]};
            chroma_mask = cbf_bits;
         end
         CHROMA_420, CHROMA_422: begin
            if (log2_size > 3'd2) begin
               log2_c      = log2_size - 3'd1;
               cbf_bits    = {cbf_cr[1] & sub1_en, cbf_cr[0], cbf_cb[1] & sub1_en, cbf_cb[0]};
               chroma_mask = cbf_bits;
            end else begin
               // 4x4 luma: chroma of the parent is decoded once, with the last quadrant
               log2_c   = 3'd2;
               cbf_bits = {parent_cbf_cr[1] & sub1_en, parent_cbf_cr[0],
                           parent_cbf_cb[1] & sub1_en, parent_cbf_cb[0]};
               if (blk_idx == 2'd3) chroma_mask = cbf_bits;
            end
         end
         default: ;
      endcase
      cbf_chroma = |cbf_bits;
      if (cfg_err) begin
         chroma_mask = '0;
         cbf_chroma  = 1'b0;
      end
   end

endmodule

// File: rtl/qdec_tu_seq.sv
// Transform-unit sequencer: walks transform_unit() syntax order and drives the
// shared DQP/CQP/residual sub-decoders through a start/done handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for tu_start; cfg latched on accept
// EVAL     | latched cfg evaluated, error check, first sub-decode chosen
// DQP      | delta QP sub-decode in flight
// CQP      | chroma QP offset sub-decode in flight
// RES_Y    | luma residual in flight
// RES_C    | chroma residuals in flight, iterating the chroma mask
// DONE     | completion pulse, back to IDLE
module qdec_tu_seq
   import qdec_cabac_package::*;
#(
   parameter int unsigned MAX_LOG2_TB = 5,
   parameter bit          SUPPORT_422 = 1'b1,
   parameter bit          SUPPORT_444 = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tu_start,
   input  logic       tu_abort,
   input  logic [1:0] chroma_format_idc,
   input  logic [2:0] log2TrafoSize,
   input  logic [1:0] blkIdx,
   input  logic       cbf_luma,
   input  logic [1:0] cbf_cb,
   input  logic [1:0] cbf_cr,
   input  logic [1:0] parent_cbf_cb,
   input  logic [1:0] parent_cbf_cr,
   input  logic       cu_transquant_bypass_flag,
   input  logic       cu_qp_delta_enabled_flag,
   input  logic       IsCuQpDeltaCoded,
   input  logic       cu_chroma_qp_offset_enabled_flag,
   input  logic       IsCuChromaQpOffsetCoded,
   output logic       sub_start,
   output logic [1:0] sub_sel,
   output logic [1:0] res_cidx,
   output logic [2:0] res_log2size,
   output logic       res_subblk,
   input  logic       sub_done,
   output logic       dqp_coded_set,
   output logic       cqp_coded_set,
   output logic [2:0] res_blk_cnt,
   output logic       tu_busy,
   output logic       cfg_err,
   output logic       tu_done_intr
);

   t_state_tu_seq state_q, state_d;
   t_tu_cfg       cfg_q, cfg_d;
   t_sub_sel      sub_sel_q, sub_sel_d;
   logic          sub_start_q, sub_start_d;
   logic [1:0]    res_cidx_q, res_cidx_d;
   logic [2:0]    res_log2size_q, res_log2size_d;
   logic          res_subblk_q, res_subblk_d;
   logic          dqp_set_q, dqp_set_d;
   logic          cqp_set_q, cqp_set_d;
   logic [2:0]    blk_cnt_q, blk_cnt_d;
   logic          busy_q, busy_d;
   logic          cfg_err_q, cfg_err_d;
   logic          done_q, done_d;
   logic [3:0]    mask_q, mask_d;

   logic [3:0]    plan_mask;
   logic [2:0]    plan_log2c;
   logic          plan_cbf_chroma;
   logic          plan_err;

   qdec_tu_chroma_plan #(
      .MAX_LOG2_TB (MAX_LOG2_TB),
      .SUPPORT_422 (SUPPORT_422),
      .SUPPORT_444 (SUPPORT_444)
   ) u_plan (
      .chroma_format_idc (cfg_q.chroma_format_idc),
      .log2_size         (cfg_q.log2_size),
      .blk_idx           (cfg_q.blk_idx),
      .cbf_cb            (cfg_q.cbf_cb),
      .cbf_cr            (cfg_q.cbf_cr),
      .parent_cbf_cb     (cfg_q.parent_cbf_cb),
      .parent_cbf_cr     (cfg_q.parent_cbf_cr),
      .chroma_mask       (plan_mask),
      .log2_c            (plan_log2c),
      .cbf_chroma        (plan_cbf_chroma),
      .cfg_err           (plan_err)
   );

   logic          need_dqp, need_cqp, done_ok;
   t_state_tu_seq res_nxt, cqp_nxt, dqp_nxt, eval_nxt;

   // Priority chain, entered at different depths from EVAL, DQP and CQP
   always_comb begin
      need_dqp = cfg_q.dqp_en & ~cfg_q.dqp_coded;
      need_cqp = cfg_q.cqp_en & plan_cbf_chroma & ~cfg_q.bypass & ~cfg_q.cqp_coded;
      res_nxt  = cfg_q.cbf_luma ? ST_RES_Y : ((|plan_mask) ? ST_RES_C : ST_DONE);
      cqp_nxt  = need_cqp ? ST_CQP : res_nxt;
      dqp_nxt  = need_dqp ? ST_DQP : cqp_nxt;
      eval_nxt = (cfg_q.cbf_luma | plan_cbf_chroma) ? dqp_nxt : ST_DONE;
      done_ok  = sub_done & ~sub_start_q;
   end

   logic          enter;
   t_state_tu_seq enter_st;
   logic          do_pick;
   logic [3:0]    pick_src;
   logic [1:0]    pick_idx;

   always_comb begin
      state_d        = state_q;
      cfg_d          = cfg_q;
      sub_start_d    = 1'b0;
      sub_sel_d      = sub_sel_q;
      res_cidx_d     = res_cidx_q;
      res_log2size_d = res_log2size_q;
      res_subblk_d   = res_subblk_q;
      dqp_set_d      = 1'b0;
      cqp_set_d      = 1'b0;
      blk_cnt_d      = blk_cnt_q;
      cfg_err_d      = cfg_err_q;
      mask_d         = mask_q;
      enter          = 1'b0;
      enter_st       = ST_IDLE;
      do_pick        = 1'b0;
      pick_src       = plan_mask;
      pick_idx       = 2'd0;

      case (state_q)
         ST_IDLE: begin
            if (tu_start) begin
               state_d   = ST_EVAL;
               cfg_d     = '{chroma_format_idc, log2TrafoSize, blkIdx, cbf_luma,
                             cbf_cb, cbf_cr, parent_cbf_cb, parent_cbf_cr,
                             cu_transquant_bypass_flag, cu_qp_delta_enabled_flag,
                             IsCuQpDeltaCoded, cu_chroma_qp_offset_enabled_flag,
                             IsCuChromaQpOffsetCoded};
               blk_cnt_d = '0;
               cfg_err_d = 1'b0;
            end
         end
         ST_EVAL: begin
            enter = 1'b1;
            if (plan_err) begin
               cfg_err_d = 1'b1;
               enter_st  = ST_DONE;
            end else begin
               enter_st  = eval_nxt;
            end
         end
         ST_DQP: begin
            if (done_ok) begin
               dqp_set_d = 1'b1;
               enter     = 1'b1;
               enter_st  = cqp_nxt;
            end
         end
         ST_CQP: begin
            if (done_ok) begin
               cqp_set_d = 1'b1;
               enter     = 1'b1;
               enter_st  = res_nxt;
            end
         end
         ST_RES_Y: begin
            if (done_ok) begin
               blk_cnt_d = blk_cnt_q + 3'd1;
               enter     = 1'b1;
               enter_st  = (|plan_mask) ? ST_RES_C : ST_DONE;
            end
         end
         ST_RES_C: begin
            if (done_ok) begin
               blk_cnt_d = blk_cnt_q + 3'd1;
               if (|mask_q) begin
                  do_pick  = 1'b1;
                  pick_src = mask_q;
               end else begin
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (enter) begin
         state_d = enter_st;
         case (enter_st)
            ST_DQP: begin
               sub_start_d = 1'b1;
               sub_sel_d   = SUB_DQP;
            end
            ST_CQP: begin
               sub_start_d = 1'b1;
               sub_sel_d   = SUB_CQP;
            end
            ST_RES_Y: begin
               sub_start_d    = 1'b1;
               sub_sel_d      = SUB_RES;
               res_cidx_d     = CIDX_Y;
               res_log2size_d = cfg_q.log2_size;
               res_subblk_d   = 1'b0;
            end
            ST_RES_C: begin
               do_pick  = 1'b1;
               pick_src = plan_mask;
            end
            default: ;
         endcase
      end

      if (do_pick) begin
         pick_idx       = first_set(pick_src);
         sub_start_d    = 1'b1;
         sub_sel_d      = SUB_RES;
         res_cidx_d     = pick_idx[1] ? CIDX_CR : CIDX_CB;
         res_subblk_d   = pick_idx[0];
         res_log2size_d = plan_log2c;
         mask_d         = pick_src & ~(4'b0001 << pick_idx);
      end

      // Abort wins over everything, including a coincident sub_done or tu_start
      if (tu_abort) begin
         state_d        = ST_IDLE;
         cfg_d          = cfg_q;
         sub_start_d    = 1'b0;
         sub_sel_d      = sub_sel_q;
         res_cidx_d     = res_cidx_q;
         res_log2size_d = res_log2size_q;
         res_subblk_d   = res_subblk_q;
         dqp_set_d      = 1'b0;
         cqp_set_d      = 1'b0;
         blk_cnt_d      = blk_cnt_q;
         cfg_err_d      = cfg_err_q;
         mask_d         = mask_q;
      end

      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cfg_q          <= '0;
         sub_start_q    <= 1'b0;
         sub_sel_q      <= SUB_DQP;
         res_cidx_q     <= '0;
         res_log2size_q <= '0;
         res_subblk_q   <= 1'b0;
         dqp_set_q      <= 1'b0;
         cqp_set_q      <= 1'b0;
         blk_cnt_q      <= '0;
         busy_q         <= 1'b0;
         cfg_err_q      <= 1'b0;
         done_q         <= 1'b0;
         mask_q         <= '0;
      end else begin
         state_q        <= state_d;
         cfg_q          <= cfg_d;
         sub_start_q    <= sub_start_d;
         sub_sel_q      <= sub_sel_d;
         res_cidx_q     <= res_cidx_d;
         res_log2size_q <= res_log2size_d;
         res_subblk_q   <= res_subblk_d;
         dqp_set_q      <= dqp_set_d;
         cqp_set_q      <= cqp_set_d;
         blk_cnt_q      <= blk_cnt_d;
         busy_q         <= busy_d;
         cfg_err_q      <= cfg_err_d;
         done_q         <= done_d;
         mask_q         <= mask_d;
      end
   end

   assign sub_start     = sub_start_q;
   assign sub_sel       = sub_sel_q;
   assign res_cidx      = res_cidx_q;
   assign res_log2size  = res_log2size_q;
   assign res_subblk    = res_subblk_q;
   assign dqp_coded_set = dqp_set_q;
   assign cqp_coded_set = cqp_set_q;
   assign res_blk_cnt   = blk_cnt_q;
   assign tu_busy       = busy_q;
   assign cfg_err       = cfg_err_q;
   assign tu_done_intr  = done_q;

endmodule

// File: tb/tb_qdec_tu_seq.sv
// Directed bench for qdec_tu_seq: per-scenario tasks with a small sub-decoder
// responder that records every sub_start as a {sel,cidx,log2,subblk} tuple.
module tb_qdec_tu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tu_start, tu_abort;
   logic [1:0] chroma_format_idc;
   logic [2:0] log2TrafoSize;
   logic [1:0] blkIdx;
   logic       cbf_luma;
   logic [1:0] cbf_cb, cbf_cr, parent_cbf_cb, parent_cbf_cr;
   logic       cu_transquant_bypass_flag;
   logic       cu_qp_delta_enabled_flag, IsCuQpDeltaCoded;
   logic       cu_chroma_qp_offset_enabled_flag, IsCuChromaQpOffsetCoded;
   logic       sub_start;
   logic [1:0] sub_sel, res_cidx;
   logic [2:0] res_log2size;
   logic       res_subblk;
   logic       sub_done;
   logic       dqp_coded_set, cqp_coded_set;
   logic [2:0] res_blk_cnt;
   logic       tu_busy, cfg_err, tu_done_intr;

   qdec_tu_seq dut (
      .clk                              (clk),
      .rst_n                            (rst_n),
      .tu_start                         (tu_start),
      .tu_abort                         (tu_abort),
      .chroma_format_idc                (chroma_format_idc),
      .log2TrafoSize                    (log2TrafoSize),
      .blkIdx                           (blkIdx),
      .cbf_luma                         (cbf_luma),
      .cbf_cb                           (cbf_cb),
      .cbf_cr                           (cbf_cr),
      .parent_cbf_cb                    (parent_cbf_cb),
      .parent_cbf_cr                    (parent_cbf_cr),
      .cu_transquant_bypass_flag        (cu_transquant_bypass_flag),
      .cu_qp_delta_enabled_flag         (cu_qp_delta_enabled_flag),
      .IsCuQpDeltaCoded                 (IsCuQpDeltaCoded),
      .cu_chroma_qp_offset_enabled_flag (cu_chroma_qp_offset_enabled_flag),
      .IsCuChromaQpOffsetCoded          (IsCuChromaQpOffsetCoded),
      .sub_start                        (sub_start),
      .sub_sel                          (sub_sel),
      .res_cidx                         (res_cidx),
      .res_log2size                     (res_log2size),
      .res_subblk                       (res_subblk),
      .sub_done                         (sub_done),
      .dqp_coded_set                    (dqp_coded_set),
      .cqp_coded_set                    (cqp_coded_set),
      .res_blk_cnt                      (res_blk_cnt),
      .tu_busy                          (tu_busy),
      .cfg_err                          (cfg_err),
      .tu_done_intr                     (tu_done_intr)
   );

   always #5 clk = ~clk;

   int         vecs = 0;
   int         errs = 0;
   logic [7:0] rec [8];
   logic [7:0] exp_t [8];
   int         n_sub, dqp_cnt, cqp_cnt, done_cyc, first_cyc;
   logic       busy1, busy_done, err_done, stab_err, timeout;
   logic [2:0] cnt_done;

   // Only residual requests carry meaningful cidx/size/subblk
   function automatic logic [7:0] tup(input logic [1:0] s, input logic [1:0] c,
                                      input logic [2:0] l, input logic sb);
      tup = (s == 2'd2) ? {s, c, l, sb} : {s, 6'b0};
   endfunction

   task automatic set_cfg(input logic [1:0] f, input logic [2:0] l, input logic [1:0] b,
                          input logic lu, input logic [1:0] cb, input logic [1:0] cr,
                          input logic [1:0] pcb, input logic [1:0] pcr, input logic byp,
                          input logic de, input logic dc, input logic ce, input logic cc);
      chroma_format_idc = f;   log2TrafoSize = l;  blkIdx = b;  cbf_luma = lu;
      cbf_cb = cb;  cbf_cr = cr;  parent_cbf_cb = pcb;  parent_cbf_cr = pcr;
      cu_transquant_bypass_flag = byp;
      cu_qp_delta_enabled_flag = de;  IsCuQpDeltaCoded = dc;
      cu_chroma_qp_offset_enabled_flag = ce;  IsCuChromaQpOffsetCoded = cc;
   endtask

   // Pulses tu_start, answers each sub_start after 'delay' cycles, stops at tu_done_intr.
   task automatic run_tu(input int delay, input bit poke_start);
      int         pend;
      logic [7:0] last;
      n_sub = 0; dqp_cnt = 0; cqp_cnt = 0; done_cyc = -1; first_cyc = -1;
      busy1 = 0; busy_done = 0; err_done = 0; stab_err = 0; timeout = 0; cnt_done = 0;
      pend = 0; last = '0;
      tu_start = 1'b1;
      @(posedge clk); #1;
      tu_start = 1'b0;
      for (int cyc = 1; cyc < 100; cyc++) begin
         if (cyc == 1) busy1 = tu_busy;
         tu_start = poke_start && (cyc == 3);
         if (dqp_coded_set) dqp_cnt++;
         if (cqp_coded_set) cqp_cnt++;
         if (tu_done_intr) begin
            done_cyc = cyc; busy_done = tu_busy; err_done = cfg_err; cnt_done = res_blk_cnt;
            break;
         end
         sub_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               sub_done = 1'b1;
               if (tup(sub_sel, res_cidx, res_log2size, res_subblk) !== last) stab_err = 1;
            end
         end
         if (sub_start) begin
            last = tup(sub_sel, res_cidx, res_log2size, res_subblk);
            if (first_cyc < 0) first_cyc = cyc;
            if (n_sub < 8) rec[n_sub] = last;
            n_sub++;
            pend = delay;
         end
         @(posedge clk); #1;
      end
      sub_done = 1'b0;
      tu_start = 1'b0;
      if (done_cyc < 0) begin
         timeout = 1;
         tu_abort = 1'b1;
      end
      @(posedge clk); #1;
      tu_abort = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tu_start = 0; tu_abort = 0; sub_done = 0;
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      if ({sub_start, sub_sel, res_cidx, res_log2size, res_subblk, dqp_coded_set, cqp_coded_set,
           res_blk_cnt, tu_busy, cfg_err, tu_done_intr} !== 18'd0) begin
         errs++;
         $display("FAIL reset_outputs got busy=%b err=%b start=%b cnt=%0d done=%b want all 0",
                  tu_busy, cfg_err, sub_start, res_blk_cnt, tu_done_intr);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_empty();
      set_cfg(1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      run_tu(1, 0);
      vecs++;
      if (done_cyc !== 2 || n_sub !== 0) begin
         errs++;
         $display("FAIL empty_latency got done_cyc=%0d n_sub=%0d want 2/0", done_cyc, n_sub);
      end
      vecs++;
      if ({busy1, busy_done} !== 2'b11) begin
         errs++;
         $display("FAIL empty_busy got eval=%b done=%b want 1/1", busy1, busy_done);
      end
      vecs++;
      if (tu_busy !== 1'b0) begin
         errs++;
         $display("FAIL empty_idle_busy got %b want 0", tu_busy);
      end
   endtask

   task automatic test_420_dqp();
      set_cfg(1, 4, 0, 1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 0);
      exp_t[0] = tup(0, 0, 0, 0);
      exp_t[1] = tup(2, 0, 4, 0);
      exp_t[2] = tup(2, 1, 3, 0);
      run_tu(2, 1);
      vecs++;
      if (timeout || n_sub !== 3) begin
         errs++;
         $display("FAIL dqp420_len got %0d (timeout %0d) want 3", n_sub, timeout);
      end
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if (rec[i] !== exp_t[i]) begin
            errs++;
            $display("FAIL dqp420_seq[%0d] got %h want %h", i, rec[i], exp_t[i]);
         end
      end
      vecs++;
      if (cnt_done !== 3'd2 || dqp_cnt !== 1 || cqp_cnt !== 0 || first_cyc !== 2) begin
         errs++;
         $display("FAIL dqp420_counts got cnt=%0d dqp=%0d cqp=%0d first=%0d want 2/1/0/2",
                  cnt_done, dqp_cnt, cqp_cnt, first_cyc);
      end
      vecs++;
      if (stab_err !== 1'b0 || res_blk_cnt !== 3'd2) begin
         errs++;
         $display("FAIL dqp420_stable got stab=%b idle_cnt=%0d want 0/2", stab_err, res_blk_cnt);
      end
   endtask

   task automatic test_422_cqp();
      set_cfg(2, 3, 0, 0, 2'b11, 2'b10, 0, 0, 0, 0, 0, 1, 0);
      exp_t[0] = tup(1, 0, 0, 0);
      exp_t[1] = tup(2, 1, 2, 0);
      exp_t[2] = tup(2, 1, 2, 1);
      exp_t[3] = tup(2, 2, 2, 1);
      run_tu(1, 0);
      vecs++;
      if (timeout || n_sub !== 4) begin
         errs++;
         $display("FAIL cqp422_len got %0d (timeout %0d) want 4", n_sub, timeout);
      end
      for (int i = 0; i < 4; i++) begin
         vecs++;
         if (rec[i] !== exp_t[i]) begin
            errs++;
            $display("FAIL cqp422_seq[%0d] got %h want %h", i, rec[i], exp_t[i]);
         end
      end
      vecs++;
      if (cnt_done !== 3'd3 || cqp_cnt !== 1 || dqp_cnt !== 0) begin
         errs++;
         $display("FAIL cqp422_counts got cnt=%0d cqp=%0d dqp=%0d want 3/1/0", cnt_done, cqp_cnt, dqp_cnt);
      end
   endtask

   task automatic test_420_parent();
      set_cfg(1, 2, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      run_tu(1, 0);
      vecs++;
      if (timeout || n_sub !== 1 || rec[0] !== tup(2, 0, 2, 0) || cnt_done !== 3'd1) begin
         errs++;
         $display("FAIL parent_blk1 got n=%0d first=%h cnt=%0d want 1/84/1", n_sub, rec[0], cnt_done);
      end
      set_cfg(1, 2, 3, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      run_tu(3, 0);
      vecs++;
      if (timeout || n_sub !== 2 || cnt_done !== 3'd2) begin
         errs++;
         $display("FAIL parent_blk3_len got n=%0d cnt=%0d want 2/2", n_sub, cnt_done);
      end
      vecs++;
      if (rec[0] !== tup(2, 0, 2, 0) || rec[1] !== tup(2, 1, 2, 0)) begin
         errs++;
         $display("FAIL parent_blk3_seq got %h %h want 84 94", rec[0], rec[1]);
      end
   endtask

   task automatic test_444_dqp_cqp();
      set_cfg(3, 5, 0, 1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0);
      exp_t[0] = tup(0, 0, 0, 0);
      exp_t[1] = tup(1, 0, 0, 0);
      exp_t[2] = tup(2, 0, 5, 0);
      exp_t[3] = tup(2, 1, 5, 0);
      run_tu(1, 0);
      vecs++;
      if (timeout || n_sub !== 4) begin
         errs++;
         $display("FAIL fmt444_len got %0d (timeout %0d) want 4", n_sub, timeout);
      end
      for (int i = 0; i < 4; i++) begin
         vecs++;
         if (rec[i] !== exp_t[i]) begin
            errs++;
            $display("FAIL fmt444_seq[%0d] got %h want %h", i, rec[i], exp_t[i]);
         end
      end
      // Bypass suppresses CQP; chroma Cb/Cr both at full size
      set_cfg(3, 3, 0, 0, 2'b01, 2'b01, 0, 0, 1, 0, 0, 1, 0);
      run_tu(2, 0);
      vecs++;
      if (timeout || n_sub !== 2 || rec[0] !== tup(2, 1, 3, 0) || rec[1] !== tup(2, 2, 3, 0) ||
          cqp_cnt !== 0) begin
         errs++;
         $display("FAIL fmt444_bypass got n=%0d %h %h cqp=%0d want 2 96 a6 0",
                  n_sub, rec[0], rec[1], cqp_cnt);
      end
   endtask

   task automatic test_cfg_err();
      set_cfg(1, 6, 0, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0);
      run_tu(1, 0);
      vecs++;
      if (done_cyc !== 2 || n_sub !== 0 || err_done !== 1'b1) begin
         errs++;
         $display("FAIL err_log2_6 got done_cyc=%0d n=%0d err=%b want 2/0/1", done_cyc, n_sub, err_done);
      end
      vecs++;
      if (cfg_err !== 1'b1) begin
         errs++;
         $display("FAIL err_sticky got %b want 1", cfg_err);
      end
      tu_abort = 1'b1; tu_start = 1'b1;
      @(posedge clk); #1;
      tu_abort = 1'b0; tu_start = 1'b0;
      vecs++;
      if (cfg_err !== 1'b1 || tu_busy !== 1'b0) begin
         errs++;
         $display("FAIL err_abort_hold got err=%b busy=%b want 1/0", cfg_err, tu_busy);
      end
      set_cfg(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_tu(1, 0);
      vecs++;
      if (done_cyc !== 2 || n_sub !== 0 || err_done !== 1'b1) begin
         errs++;
         $display("FAIL err_log2_1 got done_cyc=%0d n=%0d err=%b want 2/0/1", done_cyc, n_sub, err_done);
      end
      set_cfg(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_tu(1, 0);
      vecs++;
      if (done_cyc !== 2 || err_done !== 1'b0 || cfg_err !== 1'b0) begin
         errs++;
         $display("FAIL err_clear got done_cyc=%0d err=%b/%b want 2/0/0", done_cyc, err_done, cfg_err);
      end
   endtask

   task automatic test_abort();
      int seen_done;
      set_cfg(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tu_start = 1'b1;
      @(posedge clk); #1;
      tu_start = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (sub_start !== 1'b1 || tup(sub_sel, res_cidx, res_log2size, res_subblk) !== tup(2, 0, 3, 0)) begin
         errs++;
         $display("FAIL abort_resy_start got start=%b sel=%0d log2=%0d want 1/2/3",
                  sub_start, sub_sel, res_log2size);
      end
      @(posedge clk); #1;
      sub_done = 1'b1; tu_abort = 1'b1;
      @(posedge clk); #1;
      sub_done = 1'b0; tu_abort = 1'b0;
      vecs++;
      if ({tu_busy, sub_start, tu_done_intr} !== 3'b000 || res_blk_cnt !== 3'd0) begin
         errs++;
         $display("FAIL abort_idle got busy=%b start=%b intr=%b cnt=%0d want 0/0/0/0",
                  tu_busy, sub_start, tu_done_intr, res_blk_cnt);
      end
      seen_done = 0;
      for (int i = 0; i < 4; i++) begin
         if (tu_done_intr || sub_start || dqp_coded_set || tu_busy) seen_done++;
         @(posedge clk); #1;
      end
      vecs++;
      if (seen_done !== 0) begin
         errs++;
         $display("FAIL abort_quiet got %0d active cycles want 0", seen_done);
      end
   endtask

   task automatic test_reset_mid();
      set_cfg(3, 3, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0);
      tu_start = 1'b1;
      @(posedge clk); #1;
      tu_start = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (sub_start !== 1'b1 || res_cidx !== 2'd1 || tu_busy !== 1'b1) begin
         errs++;
         $display("FAIL resetmid_resc got start=%b cidx=%0d busy=%b want 1/1/1", sub_start, res_cidx, tu_busy);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      vecs++;
      if ({sub_start, sub_sel, res_cidx, res_log2size, res_subblk, dqp_coded_set, cqp_coded_set,
           res_blk_cnt, tu_busy, cfg_err, tu_done_intr} !== 18'd0) begin
         errs++;
         $display("FAIL resetmid_async got busy=%b sel=%0d cidx=%0d log2=%0d want all 0",
                  tu_busy, sub_sel, res_cidx, res_log2size);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_empty();
      test_420_dqp();
      test_422_cqp();
      test_420_parent();
      test_444_dqp_cqp();
      test_cfg_err();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/qdec_tu_seq.md
Name: qdec_tu_seq

Overview:
- Parametrised transform-unit sequencer for the CABAC decoder; successor to the fixed 4:2:0 TU FSM.
- Walks the HEVC transform_unit() syntax order for chroma formats 4:0:0, 4:2:0, 4:2:2 and 4:4:4:
  - delta QP, then chroma QP offset;
  - luma residual;
  - Cb/Cr residuals, including the two vertically stacked chroma blocks of 4:2:2 and deferred parent chroma at blkIdx 3.
- Drives shared dqp/cqp/residual sub-decoders through a start/done handshake. Supports abort and configuration-error reporting.

Parameters:
- MAX_LOG2_TB, 5, largest legal log2TrafoSize; the smallest is fixed at 2.
- SUPPORT_422, 1, 0 makes chroma_format_idc==2 a configuration error.
- SUPPORT_444, 1, 0 makes chroma_format_idc==3 a configuration error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tu_start  in  1  start pulse; accepted only in IDLE, all cfg inputs latched on that cycle
- tu_abort  in  1  synchronous abort; highest priority
- chroma_format_idc  in  2  0=mono, 1=4:2:0, 2=4:2:2, 3=4:4:4
- log2TrafoSize  in  3  luma TB size
- blkIdx  in  2  index within parent split
- cbf_luma  in  1  luma coded block flag
- cbf_cb, cbf_cr  in  2 each  chroma cbf per sub-block; bit1 used only for 4:2:2
- parent_cbf_cb, parent_cbf_cr  in  2 each  parent chroma cbfs
- cu_transquant_bypass_flag  in  1  bypass flag
- cu_qp_delta_enabled_flag, IsCuQpDeltaCoded  in  1 each  DQP gating
- cu_chroma_qp_offset_enabled_flag, IsCuChromaQpOffsetCoded  in  1 each  CQP gating
- sub_start  out  1  one-cycle request to the selected sub-decoder
- sub_sel  out  2  0=DQP, 1=CQP, 2=RES
- res_cidx  out  2  0=Y, 1=Cb, 2=Cr
- res_log2size  out  3  size of the residual block
- res_subblk  out  1  4:2:2 lower sub-block
- sub_done  in  1  one-cycle completion from the selected sub-decoder
- dqp_coded_set, cqp_coded_set  out  1 each  pulse when DQP/CQP completes
- res_blk_cnt  out  3  residual blocks completed in the current TU
- tu_busy  out  1  high from the cycle after accept until DONE inclusive
- cfg_err  out  1  sticky; cleared on next accepted tu_start
- tu_done_intr  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0.
  - Latched cfg cleared.
- States: IDLE, EVAL, DQP, CQP, RES_Y, RES_C, DONE.
- IDLE → EVAL on tu_start. tu_start in any other state is ignored.
- EVAL derivations:
  - cfg_err=1 and go to DONE if any of these hold:
    - log2TrafoSize<2 or log2TrafoSize>MAX_LOG2_TB;
    - the format is disabled by SUPPORT_422/SUPPORT_444.
  - 4:4:4: log2C=log2TrafoSize; chroma uses cbf_cb[0]/cbf_cr[0].
  - 4:2:0 or 4:2:2 with log2>2: log2C=log2-1; chroma uses cbf bits.
  - 4:2:0 or 4:2:2 with log2==2: log2C=2; chroma uses the parent bits and is decoded only when blkIdx==3.
  - 4:2:2 enables sub-block 1; other formats use bit0 only.
  - Mono: no chroma.
  - cbfChroma = OR of the applicable bits, taken regardless of blkIdx.
- EVAL exit order:
  - DONE if !(cbf_luma|cbfChroma).
  - Else DQP if cu_qp_delta_enabled_flag & !IsCuQpDeltaCoded.
  - Else CQP if cu_chroma_qp_offset_enabled_flag & cbfChroma & !cu_transquant_bypass_flag & !IsCuChromaQpOffsetCoded.
  - Else RES_Y if cbf_luma.
  - Else RES_C if any chroma mask bit is set.
  - Else DONE.
  - The same priority chain applies on exit from DQP and CQP.
- sub_start handshake:
  - Registered; asserted exactly in the first cycle of each sub-decode (state entry, or chroma index advance).
  - sub_sel, res_cidx, res_log2size and res_subblk are stable from sub_start until sub_done.
  - sub_done is sampled only after sub_start; sub_done in the same cycle as sub_start, or outside sub-decode states, is ignored.
- RES_C:
  - 4-bit mask {Cr1,Cr0,Cb1,Cb0}, iterated in the order Cb0, Cb1, Cr0, Cr1, skipping zeros.
  - On sub_done, the next set bit issues sub_start on the following cycle. No set bit remaining → DONE.
- res_blk_cnt increments on each RES sub_done and clears on accept.
- DONE: tu_done_intr=1 for that cycle, then IDLE.
- Latency: empty TU → tu_done_intr in cycle 2 after the tu_start cycle. First sub_start occurs in cycle 2.
- tu_abort: next state IDLE from any state, overriding sub_done.
  - No tu_done_intr or coded_set pulse.
  - sub_start deasserts; cfg_err is held.

Decomposition:
- qdec_cabac_package holds:
  - enum t_state_tu_seq;
  - enum t_sub_sel (SUB_DQP, SUB_CQP, SUB_RES);
  - constants CHROMA_400/420/422/444 and CIDX_Y/CB/CR.
- Sub-module qdec_tu_chroma_plan (combinational): maps latched cfg to chroma mask, log2C, cbfChroma and cfg_err.

Test Plan:
- 4:2:0, log2=4, cbf_luma=1, cbf_cb=01, cbf_cr=00, DQP enabled and not coded → sub_sel sequence DQP, RES(Y,4), RES(Cb,3); res_blk_cnt=2; dqp_coded_set once.
- 4:2:2, log2=3, cbf_cb=11, cbf_cr=10, cbf_luma=0, CQP enabled → CQP, then Cb0, Cb1, Cr1 at log2C=2 with res_subblk 0,1,1.
- 4:2:0, log2=2, blkIdx=1, parent_cbf_cb=01, cbf_luma=1 → Y only. Same with blkIdx=3 → Y then Cb(2).
- All cbf=0, tu_start at cycle 0 → tu_done_intr in cycle 2, no sub_start.
- log2=6 with MAX_LOG2_TB=5, or format 4:4:4 with SUPPORT_444=0 → cfg_err=1, tu_done_intr, no sub_start. cfg_err clears on next legal tu_start.
- tu_abort during RES_Y coincident with sub_done → IDLE next cycle, no tu_done_intr, res_blk_cnt unchanged. Reset asserted mid-RES_C → all outputs 0 asynchronously.
